// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller: FSM state encoding and a
// decode helper used wherever scan-enable is derived from the state.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_FINISH  = 3'd4
  } scan_state_e;

  localparam scan_state_e RESET_STATE = ST_IDLE;

  // The chain shifts in exactly these two states.
  function automatic logic is_shift_state(input scan_state_e s);
    return (s == ST_LOAD) || (s == ST_UNLOAD);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load, right-shifting capture register with a saturating shift
// counter; serial data enters at the MSB.
module scan_shift_reg
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data_i,
  input  logic                 clr_i,
  input  logic                 shift_en,
  input  logic                 ser_in,
  output logic [CHAIN_LEN-1:0] q_o,
  output logic [CNT_W-1:0]     cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Next-state: load has priority over clear, clear over shift.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_data_i;
      cnt_d   = '0;
    end else if (clr_i) begin
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {ser_in, shift_q[CHAIN_LEN-1:1]};
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o   = shift_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: loads a pattern into an external scan chain, optionally
// pulses one capture cycle, and unloads the chain contents into rdata.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] wdata,
  output logic                 se,
  output logic                 si,
  input  logic                 so,
  output logic                 cap_clk_en,
  output logic                 busy,
  output logic [CHAIN_LEN-1:0] rdata,
  output logic                 done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state_q, state_d;
  logic                 cap_q, cap_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic                 load_s;
  logic [CHAIN_LEN-1:0] shift_s;
  logic [CNT_W-1:0]     cnt_s;

  scan_shift_reg #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_shift (
    .CLK         (CLK),
    .RN          (RN),
    .load        (load_s),
    .load_data_i (wdata),
    .clr_i       (state_q == ST_CAPTURE),
    .shift_en    (is_shift_state(state_q)),
    .ser_in      (so),
    .q_o         (shift_s),
    .cnt_o       (cnt_s)
  );

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cap_d   = capture_en;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_s == LAST_CNT) begin
          state_d = cap_q ? ST_CAPTURE : ST_FINISH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CAPTURE: state_d = ST_UNLOAD;
      ST_UNLOAD: begin
        if (cnt_s == LAST_CNT) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_UNLOAD;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        rdata_d = shift_s;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State, latched capture request and held result.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= RESET_STATE;
      cap_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode the state register only; rdata shows the fresh result during FINISH.
  assign se         = is_shift_state(state_q);
  assign si         = (state_q == ST_LOAD) & shift_s[0];
  assign cap_clk_en = (state_q == ST_CAPTURE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign rdata      = (state_q == ST_FINISH) ? shift_s : rdata_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural scan chain models for a 16-cell and a
// 2-cell chain, a table of operations, and hand sequences for reset/busy cases.
module tb_scan_chain_ctrl;

  localparam int N = 16;

  logic CLK = 1'b0;
  logic RN;
  always #5 CLK = ~CLK;

  logic         start, capture_en, se, si, so, cap_clk_en, busy, done;
  logic [N-1:0] wdata, rdata;
  logic [N-1:0] chain, preset_val, cap_val;
  logic         preset_req;

  logic         start2, capture_en2, se2, si2, so2, cap_clk_en2, busy2, done2;
  logic [1:0]   wdata2, rdata2, chain2, preset_val2, cap_val2;
  logic         preset_req2;

  scan_chain_ctrl dut (
    .CLK(CLK), .RN(RN), .start(start), .capture_en(capture_en), .wdata(wdata),
    .se(se), .si(si), .so(so), .cap_clk_en(cap_clk_en), .busy(busy),
    .rdata(rdata), .done(done)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2)) dut2 (
    .CLK(CLK), .RN(RN), .start(start2), .capture_en(capture_en2), .wdata(wdata2),
    .se(se2), .si(si2), .so(so2), .cap_clk_en(cap_clk_en2), .busy(busy2),
    .rdata(rdata2), .done(done2)
  );

  // Chain models: chain[0] is the cell feeding so; si enters at the far end.
  assign so  = chain[0];
  assign so2 = chain2[0];
  always @(posedge CLK) begin
    if (preset_req) chain <= preset_val;
    else if (cap_clk_en) chain <= cap_val;
    else if (se) chain <= {si, chain[N-1:1]};
  end
  always @(posedge CLK) begin
    if (preset_req2) chain2 <= preset_val2;
    else if (cap_clk_en2) chain2 <= cap_val2;
    else if (se2) chain2 <= {si2, chain2[1]};
  end

  typedef struct {
    logic [N-1:0] preset;
    logic [N-1:0] wdata;
    logic         cap;
    logic [N-1:0] capv;
    logic [N-1:0] exp_rdata;
    logic [N-1:0] exp_chain;
    int           exp_lat;
    logic         mid;
  } vec_t;

  typedef struct {
    logic [N-1:0] rdata;
    int           lat;
  } exp_t;

  vec_t         vecs[4];
  exp_t         sb[$];
  int           n_pass = 0;
  int           n_total = 0;
  logic [N-1:0] last_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one operation on the 16-cell DUT; call at #1 after an edge with the DUT idle.
  task automatic run16(input vec_t v);
    exp_t e;
    logic [N-1:0] si_got;
    int c, se_err, hold_err, cap_cnt, cap_at, done_at, extra;
    si_got = '0; se_err = 0; hold_err = 0; cap_cnt = 0; cap_at = 0; done_at = 0; extra = 0;
    start = 1'b1; wdata = v.wdata; capture_en = v.cap;
    preset_val = v.preset; preset_req = 1'b1; cap_val = v.capv;
    e.rdata = v.exp_rdata; e.lat = v.exp_lat;
    sb.push_back(e);
    @(posedge CLK); #1;
    start = 1'b0; preset_req = 1'b0;
    c = 1;
    while (c <= 100 && done_at == 0) begin
      if (c <= N) begin
        if (se !== 1'b1) se_err++;
        si_got[c-1] = si;
      end
      if (cap_clk_en === 1'b1) begin cap_cnt++; cap_at = c; end
      if (done === 1'b1) begin
        done_at = c;
      end else begin
        if (rdata !== last_rdata) hold_err++;
        if (v.mid && c == 5) begin
          start = 1'b1; wdata = ~v.wdata; capture_en = ~v.cap;
        end else begin
          start = 1'b0;
        end
        @(posedge CLK); #1;
        c++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_at != 0), 32'd1);
    e = sb.pop_front();
    check("latency", 32'(done_at), 32'(e.lat));
    check("rdata_at_done", 32'(rdata), 32'(e.rdata));
    check("busy_at_done", 32'(busy), 32'd1);
    check("se_at_done", 32'(se), 32'd0);
    check("si_stream", 32'(si_got), 32'(v.wdata));
    check("se_during_load", 32'(se_err), 32'd0);
    check("rdata_hold", 32'(hold_err), 32'd0);
    check("cap_count", 32'(cap_cnt), 32'(v.cap));
    if (v.cap) check("cap_cycle", 32'(cap_at), 32'(N + 1));
    @(posedge CLK); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("rdata_held", 32'(rdata), 32'(e.rdata));
    check("chain_after", 32'(chain), 32'(v.exp_chain));
    last_rdata = e.rdata;
    if (v.mid) begin
      for (int k = 0; k < 40; k++) begin
        if (done === 1'b1 || busy === 1'b1) extra++;
        @(posedge CLK); #1;
      end
      check("ignored_start", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    exp_t e2;
    int c, done_at, cap_at, bad;
    logic [1:0] si2_got;

    vecs[0] = '{16'h1234, 16'hA5C3, 1'b0, 16'h0000, 16'h1234, 16'hA5C3, 17, 1'b0};
    vecs[1] = '{16'h1234, 16'hA5C3, 1'b1, 16'hBEEF, 16'hBEEF, 16'h0000, 34, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 16'h0001, 17, 1'b1};
    vecs[3] = '{16'h8001, 16'h7FFE, 1'b1, 16'h0001, 16'h0001, 16'h0000, 34, 1'b1};

    RN = 1'b0; start = 1'b0; capture_en = 1'b0; wdata = '0;
    preset_req = 1'b0; preset_val = '0; cap_val = '0;
    start2 = 1'b0; capture_en2 = 1'b0; wdata2 = '0;
    preset_req2 = 1'b0; preset_val2 = '0; cap_val2 = '0;
    last_rdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_se", 32'(se), 32'd0);
    check("rst_si", 32'(si), 32'd0);
    check("rst_cap", 32'(cap_clk_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_rdata2", 32'(rdata2), 32'd0);
    RN = 1'b1;

    // Back-to-back table: each op starts in the cycle right after the previous done.
    for (int i = 0; i < 4; i++) run16(vecs[i]);

    // Reset during LOAD cycle 8 aborts without done.
    start = 1'b1; wdata = 16'hA5C3; capture_en = 1'b0;
    preset_val = 16'h1234; preset_req = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; preset_req = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    RN = 1'b0;
    #1;
    check("arst_se", 32'(se), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rdata", 32'(rdata), 32'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("rst_no_done", 32'(bad), 32'd0);
    RN = 1'b1;
    last_rdata = '0;
    run16(vecs[0]);

    // Two-cell chain with capture.
    start2 = 1'b1; wdata2 = 2'b10; capture_en2 = 1'b1;
    preset_val2 = 2'b11; preset_req2 = 1'b1; cap_val2 = 2'b01;
    e2.rdata = 16'h0001; e2.lat = 6;
    sb.push_back(e2);
    @(posedge CLK); #1;
    start2 = 1'b0; preset_req2 = 1'b0;
    c = 1; done_at = 0; cap_at = 0; si2_got = '0;
    while (c <= 50 && done_at == 0) begin
      if (c <= 2) si2_got[c-1] = si2;
      if (cap_clk_en2 === 1'b1) cap_at = c;
      if (done2 === 1'b1) begin
        done_at = c;
      end else begin
        @(posedge CLK); #1;
        c++;
      end
    end
    e2 = sb.pop_front();
    check("len2_latency", 32'(done_at), 32'(e2.lat));
    check("len2_si", 32'(si2_got), 32'd2);
    check("len2_cap_cycle", 32'(cap_at), 32'd3);
    check("len2_rdata", 32'(rdata2), 32'(e2.rdata));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, giving the number of dffq cells in the controlled scan chain (legal range 2..256).
REQ-002 SHALL have parameter CNT_W, default $clog2(CHAIN_LEN+1), giving the width of the shift counter.
REQ-003 CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-004 RN  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to run a scan operation; sampled only in IDLE.
REQ-006 capture_en  input  1  sampled with start; 1 = insert a capture cycle between load and unload.
REQ-007 wdata  input  CHAIN_LEN  pattern to load into the chain; sampled with start.
REQ-008 se  output  1  scan enable to the chain muxes; 1 = shift, 0 = functional/capture.
REQ-009 si  output  1  serial data into chain cell 0.
REQ-010 so  input  1  serial data from chain cell CHAIN_LEN-1.
REQ-011 cap_clk_en  output  1  one-cycle enable for the functional capture clock gate.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 rdata  output  CHAIN_LEN  unloaded chain contents; valid when done=1 and held until the next start is accepted.
REQ-014 done  output  1  one-cycle pulse marking the end of an operation.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, CAPTURE, UNLOAD and FINISH.
REQ-016 IDLE->LOAD when start=1: latch wdata into the shift register, latch capture_en, clear the counter.
REQ-017 LOAD: se=1 and si=shift_reg[0]; each cycle shift the register right by one and increment the counter.
REQ-018 LOAD ends after exactly CHAIN_LEN cycles; next state is CAPTURE if capture_en=1, else FINISH.
REQ-019 LOAD without capture: so is sampled into shift_reg[CHAIN_LEN-1] each LOAD cycle, so the old chain contents are unloaded concurrently.
REQ-020 CAPTURE: exactly 1 cycle with se=0 and cap_clk_en=1; then enter UNLOAD with the counter cleared.
REQ-021 UNLOAD: se=1 and si=0; so is shifted into shift_reg MSB-first-in for exactly CHAIN_LEN cycles; then enter FINISH.
REQ-022 With capture, the values sampled from so during LOAD are discarded; rdata reflects post-capture data only.
REQ-023 FINISH: 1 cycle with done=1, rdata updated from shift_reg, busy=1; then IDLE.
REQ-024 Cycle counts from start accepted to done: CHAIN_LEN+1 without capture, 2*CHAIN_LEN+2 with capture.
REQ-025 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-026 se SHALL be 0 in IDLE, CAPTURE and FINISH; cap_clk_en SHALL be 0 outside CAPTURE.
REQ-027 All outputs SHALL be registered or decoded directly from the state register, with no combinational path from start or so.
REQ-028 The counter SHALL saturate at CHAIN_LEN and never wrap.

Reset
REQ-029 When RN=0, SHALL asynchronously force state=IDLE, se=0, si=0, cap_clk_en=0, busy=0, done=0, rdata=0, shift_reg=0 and counter=0.
REQ-030 Reset asserted mid-operation SHALL abort it with no done pulse; chain contents are then undefined to software.
REQ-031 Release of RN SHALL take effect on the first CLK rising edge after deassertion; start is honoured from that edge.

Structure
REQ-032 A shared package scan_ctrl_pkg SHALL hold the state enum type and the encoded state constants.
REQ-033 The shift register plus counter SHALL be one sub-module, scan_shift_reg, parameterised by CHAIN_LEN, with load, shift_en and ser_in ports.
REQ-034 The FSM SHALL reside in scan_chain_ctrl.

Verification
REQ-035 CHAIN_LEN=16, start, capture_en=0, wdata=16'hA5C3, bench chain preset to 16'h1234 -> si emits A5C3 LSB-first over 16 cycles; done at cycle 17; rdata=16'h1234.
REQ-036 Same configuration with capture_en=1, bench capture logic loading 16'hBEEF -> cap_clk_en high exactly 1 cycle after 16 load cycles; done at cycle 34; rdata=16'hBEEF.
REQ-037 start pulsed at cycle 5 of a busy operation -> ignored; exactly one done pulse; no state change.
REQ-038 RN asserted at cycle 8 of LOAD -> se=0, busy=0 immediately (asynchronously); no done; a new start after release completes normally.
REQ-039 CHAIN_LEN=2 with capture, wdata=2'b10 -> si sequence 0,1; done at cycle 6.
REQ-040 Back-to-back start pulsed in the cycle after done -> accepted, and rdata holds its previous value until the next FINISH.
